// File: rtl/im2col_window_ctrl.sv
// im2col_window_ctrl: walks every kernel window over an IMG_SIZE x IMG_SIZE
// image, issues synchronous image-buffer reads in patch order and streams the
// returned pixels through a 2-entry output FIFO. Reads are throttled by a
// credit check so the FIFO can never overflow under backpressure.
module im2col_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_SIZE   = 5,
  localparam int CW        = $clog2(IMG_SIZE)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [2:0]            k,
  input  logic                  stride,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  rd_en,
  output logic [CW-1:0]         rd_row,
  output logic [CW-1:0]         rd_col,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_col_last,
  output logic                  out_frame_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic                  stride_q, stride_d;
  // Window origin (row/col of the patch's top-left pixel) and kernel offsets
  logic [CW-1:0]         orow_q, orow_d, ocol_q, ocol_d;
  logic [CW-1:0]         ky_q, ky_d, kx_q, kx_d;
  logic                  cfg_err_q, cfg_err_d;

  // One read in flight: its data arrives next cycle, tags travel alongside
  logic                  infl_q;
  logic                  infl_cl_q, infl_fl_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [1:0]            fifo_cl_q, fifo_fl_q;
  logic                  wptr_q, rptr_q;
  logic [1:0]            cnt_q, cnt_d;

  logic [7:0]            k_w, step_w;
  logic                  kx_end, ky_end, ocol_end, orow_end;
  logic                  iss_cl, iss_fl;
  logic                  k_bad, start_ok, pop, credit_ok;
  logic [2:0]            occ;

  // Counter end conditions; an origin is the last one when the next origin
  // would push the kernel past the image edge, which avoids a divider.
  assign k_w      = 8'(k_q);
  assign step_w   = stride_q ? 8'd2 : 8'd1;
  assign kx_end   = (8'(kx_q) == k_w - 8'd1);
  assign ky_end   = (8'(ky_q) == k_w - 8'd1);
  assign ocol_end = (8'(ocol_q) + step_w + k_w > 8'(IMG_SIZE));
  assign orow_end = (8'(orow_q) + step_w + k_w > 8'(IMG_SIZE));
  assign iss_cl   = kx_end & ky_end;
  assign iss_fl   = iss_cl & ocol_end & orow_end;

  assign k_bad    = (k == 3'd0) || (8'(k) > 8'(IMG_SIZE));
  assign start_ok = start & (state_q == S_IDLE) & ~k_bad;
  assign cfg_err_d = start & (state_q == S_IDLE) & k_bad;

  // Credit: FIFO entries plus the in-flight read, net of this cycle's pop
  assign pop       = out_valid & out_ready;
  assign occ       = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
  assign credit_ok = (occ < 3'd2);
  assign cnt_d     = cnt_q + 2'(infl_q) - 2'(pop);

  assign rd_row  = orow_q + ky_q;
  assign rd_col  = ocol_q + kx_q;
  assign cfg_err = cfg_err_q;

  assign out_valid      = (cnt_q != 2'd0);
  assign out_data       = out_valid ? fifo_data_q[rptr_q] : '0;
  assign out_col_last   = out_valid & fifo_cl_q[rptr_q];
  assign out_frame_last = out_valid & fifo_fl_q[rptr_q];

  // Next-state, counter advance and read strobe for the window walk
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    stride_d = stride_q;
    orow_d   = orow_q;
    ocol_d   = ocol_q;
    ky_d     = ky_q;
    kx_d     = kx_q;
    rd_en    = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d  = S_RUN;
          k_d      = k;
          stride_d = stride;
          orow_d   = '0;
          ocol_d   = '0;
          ky_d     = '0;
          kx_d     = '0;
        end
      end
      S_RUN: begin
        rd_en = credit_ok;
        if (credit_ok) begin
          if (!kx_end) begin
            kx_d = kx_q + CW'(1);
          end else begin
            kx_d = '0;
            if (!ky_end) begin
              ky_d = ky_q + CW'(1);
            end else begin
              ky_d = '0;
              if (!ocol_end) begin
                ocol_d = CW'(8'(ocol_q) + step_w);
              end else begin
                ocol_d = '0;
                if (!orow_end) begin
                  orow_d = CW'(8'(orow_q) + step_w);
                end else begin
                  orow_d  = '0;
                  state_d = S_DRAIN;
                end
              end
            end
          end
        end
      end
      S_DRAIN: begin
        // Leave once the last element is handed off this cycle or already gone
        if (!infl_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: FSM, latched config, counters, FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      stride_q  <= 1'b0;
      orow_q    <= '0;
      ocol_q    <= '0;
      ky_q      <= '0;
      kx_q      <= '0;
      cfg_err_q <= 1'b0;
      infl_q    <= 1'b0;
      cnt_q     <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      stride_q  <= stride_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      ky_q      <= ky_d;
      kx_q      <= kx_d;
      cfg_err_q <= cfg_err_d;
      infl_q    <= rd_en;
      cnt_q     <= cnt_d;
      if (infl_q) wptr_q <= ~wptr_q;
      if (pop)    rptr_q <= ~rptr_q;
    end
  end

  // Payload capture: tags at issue, pixel plus tags into the FIFO on return
  always_ff @(posedge clk) begin
    if (rd_en) begin
      infl_cl_q <= iss_cl;
      infl_fl_q <= iss_fl;
    end
    if (infl_q) begin
      fifo_data_q[wptr_q] <= rd_data;
      fifo_cl_q[wptr_q]   <= infl_cl_q;
      fifo_fl_q[wptr_q]   <= infl_fl_q;
    end
  end

endmodule

// File: tb/tb_im2col_window_ctrl.sv
// Testbench for im2col_window_ctrl: synchronous image buffer model, a
// loop-nest reference model of the patch stream, directed and random frames.
module tb_im2col_window_ctrl;

  localparam int DW  = 8;
  localparam int IMG = 5;
  localparam int CW  = $clog2(IMG);

  logic          clk = 1'b0;
  logic          nrst, start, stride, out_ready;
  logic [2:0]    k;
  logic          busy, done, cfg_err, rd_en, out_valid, out_col_last, out_frame_last;
  logic [CW-1:0] rd_row, rd_col;
  logic [DW-1:0] rd_data, out_data;

  logic [DW-1:0]   img [IMG][IMG];
  logic [DW+1:0]   exp_q [$];
  int              tests = 0;
  int              fails = 0;

  im2col_window_ctrl #(.DATA_WIDTH(DW), .IMG_SIZE(IMG)) dut (
    .clk(clk), .nrst(nrst), .start(start), .k(k), .stride(stride),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col_last(out_col_last), .out_frame_last(out_frame_last)
  );

  always #5 clk = ~clk;

  // Image buffer: data valid exactly one cycle after the read strobe
  always @(posedge clk) if (rd_en) rd_data <= img[rd_row][rd_col];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference stream: every window, every kernel element, in patch order
  task automatic build_exp(input int kk, input int st);
    int s, od;
    exp_q.delete();
    s  = st ? 2 : 1;
    od = (IMG - kk) / s + 1;
    for (int oy = 0; oy < od; oy++)
      for (int ox = 0; ox < od; ox++)
        for (int ky = 0; ky < kk; ky++)
          for (int kx = 0; kx < kk; kx++) begin
            logic cl, fl;
            cl = (ky == kk - 1) && (kx == kk - 1);
            fl = cl && (oy == od - 1) && (ox == od - 1);
            exp_q.push_back({fl, cl, img[oy*s+ky][ox*s+kx]});
          end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++) img[r][c] = DW'(10 * r + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++) img[r][c] = DW'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'({rd_row, rd_col}), 0);
    chk({tag, "_out"}, 32'({out_valid, out_col_last, out_frame_last, out_data}), 0);
  endtask

  // Runs one frame from a start pulse; abort_at>0 returns after that many beats
  task automatic run_frame(input int kk, input int st, input int rdy_pct, input int abort_at);
    int            cyc, got, issued, total, last_cyc, popnow;
    logic          prev_stall, exp_done;
    logic [DW+1:0] prev_out, cur_out, e;
    build_exp(kk, st);
    total = exp_q.size();
    got = 0; issued = 0; last_cyc = 0; prev_stall = 1'b0; prev_out = '0;
    start = 1'b1; k = 3'(kk); stride = st[0];
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (abort_at > 0 && got == abort_at) begin
        out_ready = 1'b1;
        return;
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      if (cyc == 5) begin
        start = 1'b1;
        k     = 3'd0;
      end
      #1;
      cur_out  = {out_frame_last, out_col_last, out_data};
      popnow   = (out_valid && out_ready) ? 1 : 0;
      exp_done = (last_cyc > 0) && (cyc == last_cyc + 1);
      chk("busy_in_frame", 32'(busy), 1);
      if (cyc == 1) chk("first_rd_en", 32'(rd_en), 1);
      if (cyc == 2) chk("valid_cycle2", 32'(out_valid), 0);
      if (cyc == 3) chk("valid_cycle3", 32'(out_valid), 1);
      if (cyc == 6) chk("start_while_busy_err", 32'(cfg_err), 0);
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_hold", 32'(cur_out), 32'(prev_out));
      end
      chk("occupancy", 32'((issued - got) <= 2), 1);
      if (rd_en) begin
        chk("credit", 32'((issued - got - popnow) < 2), 1);
        chk("addr_range", 32'((rd_row < IMG) && (rd_col < IMG)), 1);
      end
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) break;
      if (popnow == 1) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", got + 1, total);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", got + 1), 32'(cur_out), 32'(e));
          got++;
          if (e[DW+1]) last_cyc = cyc;
        end
      end
      if (rd_en) issued++;
      prev_stall = out_valid && !out_ready;
      prev_out   = cur_out;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("beat_count", got, total);
    @(posedge clk); #1;
    chk("idle_after_done", 32'({busy, done}), 0);
  endtask

  task automatic bad_start(input int kk);
    start = 1'b1; k = 3'(kk); stride = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 1);
    chk("cfg_err_busy", 32'(busy), 0);
    chk("cfg_err_rd_en", 32'(rd_en), 0);
    @(posedge clk); #1;
    chk("cfg_err_clear", 32'(cfg_err), 0);
    chk("cfg_err_busy2", 32'(busy), 0);
    chk("cfg_err_rd_en2", 32'(rd_en), 0);
  endtask

  initial begin
    nrst = 1'b1; start = 1'b0; k = 3'd0; stride = 1'b0; out_ready = 1'b1;
    fill_ramp();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    nrst = 1'b0;
    @(posedge clk); #1;

    // Directed frames on the ramp image
    run_frame(3, 0, 100, 0);
    run_frame(3, 1, 100, 0);
    run_frame(5, 0, 100, 0);
    run_frame(3, 0, 30, 0);

    // Rejected configurations, then a legal frame
    bad_start(0);
    bad_start(6);
    run_frame(2, 1, 100, 0);

    // Reset mid-frame with a read in flight, then a full frame
    run_frame(3, 0, 100, 20);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("abort");
    nrst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(out_valid), 0);
      chk("abort_no_done", 32'(done), 0);
    end
    run_frame(3, 0, 100, 0);

    // Random images, kernel sizes, strides and backpressure
    for (int i = 0; i < 6; i++) begin
      fill_random();
      run_frame(int'($urandom_range(1, 5)), int'($urandom_range(0, 1)),
                int'($urandom_range(40, 100)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/im2col_window_ctrl.md
Name: im2col_window_ctrl

Overview:
Sequencer for the im2col patch-extraction datapath. On `start` it walks every kernel window over an IMG_SIZE x IMG_SIZE image held in an external synchronous-read image buffer, generating buffer read addresses. It streams the fetched pixels out one element per beat in patch (column) order over a valid/ready interface toward the PE array. It owns all window/kernel counters, stride handling, backpressure and completion signalling.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_SIZE, 5, image height = width in pixels; legal 2..16
CW, $clog2(IMG_SIZE), derived; coordinate width, not overridable

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to begin a frame; sampled only in IDLE
k  in  3  kernel size, legal 1..IMG_SIZE; latched on accepted start
stride  in  1  0 = stride 1, 1 = stride 2; latched on accepted start
busy  out  1  high from accepted start until done pulse (inclusive)
done  out  1  one-cycle pulse after final element handshake
cfg_err  out  1  one-cycle pulse when start is rejected for illegal k
rd_en  out  1  image buffer read strobe
rd_row  out  CW  read row address
rd_col  out  CW  read column address
rd_data  in  DATA_WIDTH  buffer data, valid exactly 1 cycle after rd_en
out_valid  out  1  output element valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH  pixel value
out_col_last  out  1  marks last element (ky=kx=k-1) of a patch
out_frame_last  out  1  marks last element of last patch

Behaviour:
- Reset (nrst=1 at clock edge): state IDLE; all counters 0; output FIFO flushed; in-flight read discarded (`rd_data` ignored the following cycle); busy, done, cfg_err, rd_en, out_valid, out_col_last, out_frame_last = 0; rd_row, rd_col, out_data = 0. Reset mid-frame aborts the frame with no done pulse.
- s = stride ? 2 : 1.
- out_dim = (IMG_SIZE - k) / s + 1, integer division.
- Patches = out_dim^2, each k^2 elements.
- Illegal k (0 or > IMG_SIZE) on start in IDLE: cfg_err pulses the next cycle; state stays IDLE; busy stays 0.
- start while not IDLE: ignored, no error.
- FSM:
  - IDLE: legal start -> RUN (latch k, stride; busy=1 next cycle).
  - RUN: issue reads. After the last address is issued -> DRAIN.
  - DRAIN: no reads. When the FIFO is empty and no read is in flight -> DONE.
  - DONE: done=1 and busy=1 for exactly one cycle -> IDLE.
- Issue order: loop nest oy (outer), ox, ky, kx (inner).
  - rd_row = oy*s + ky; rd_col = ox*s + kx.
  - Addresses are always < IMG_SIZE by construction.
- Output path: 2-entry FIFO.
  - `rd_data` is pushed in the cycle after its rd_en, together with tag bits col_last and frame_last computed at issue time.
  - out_* reflect the FIFO head.
- Credit rule: rd_en asserted in RUN only when (fifo_count + inflight - pop_this_cycle) < 2, where pop = out_valid & out_ready. FIFO never overflows.
- Throughput and latency:
  - With out_ready held high: 1 element/cycle sustained.
  - Timing: start at cycle 0 -> first rd_en at cycle 1 -> first out_valid at cycle 3.
- out_valid/out_data/tags are held stable while out_valid=1 and out_ready=0.
- Push and pop in the same cycle: occupancy unchanged.
- done fires the cycle after the handshake of the out_frame_last element at the earliest.
- Frame with k=IMG_SIZE: single patch; out_col_last and out_frame_last both set on its final element.
- Total beats per frame: out_dim^2 * k^2.

Test Plan:
- IMG_SIZE=5, k=3, stride=0, image[r][c]=10r+c, out_ready=1:
  - 81 beats.
  - Patch 0 data 0,1,2,10,11,12,20,21,22.
  - Patch 1 starts at 1; patch 3 starts at 10.
  - out_col_last on beats 9,18,…,81; out_frame_last only on beat 81.
  - done exactly 1 cycle later.
- k=3, stride=1:
  - out_dim=2, 36 beats.
  - Patch origins (0,0),(0,2),(2,0),(2,2); patch 1 data 2,3,4,12,13,14,22,23,24.
- k=5, stride=0:
  - 25 beats, data 0..44 in row order.
  - Beat 25 carries both last flags.
- k=3, stride=0, out_ready random 30% high:
  - Stream identical to the first scenario.
  - out_data stable during stalls; FIFO occupancy never exceeds 2; no rd_en while credits are exhausted.
- start with k=0, then with k=6:
  - Each produces a cfg_err 1-cycle pulse.
  - busy=0, no rd_en; a subsequent legal start runs normally.
- nrst asserted at beat 20 of a k=3 frame, with a read in flight:
  - Next cycle all outputs 0, no done.
  - A new start produces a complete 81-beat frame from patch 0.
